// File: rtl/seq_detect_param.sv
// Serial pattern detector with a runtime-loadable pattern (1..PAT_MAX bits),
// overlapping/non-overlapping modes and a saturating match counter.
module seq_detect_param #(
  parameter int PAT_MAX = 8,
  parameter int CNT_W   = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cfg_load,
  input  logic [PAT_MAX-1:0] cfg_pattern,
  input  logic [4:0]         cfg_len,
  input  logic               cfg_overlap,
  input  logic               din_valid,
  input  logic               din,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               armed,
  output logic               cfg_err
);

  typedef enum logic {IDLE = 1'b0, ARMED = 1'b1} state_t;

  localparam logic [4:0] PAT_MAX_L = 5'(PAT_MAX);

  state_t             state_q, state_d;
  logic [PAT_MAX-1:0] pat_q, pat_d;
  logic [4:0]         len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [PAT_MAX-1:0] hist_q, hist_d;
  logic [4:0]         fill_q, fill_d;
  logic               match_q, match_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;

  logic [PAT_MAX-1:0] len_mask;
  logic               cfg_ok;

  // Selects the low len_q bits of history/pattern that take part in a match.
  generate
    for (genvar gi = 0; gi < PAT_MAX; gi++) begin : g_mask
      assign len_mask[gi] = (5'(gi) < len_q);
    end
  endgenerate

  assign cfg_ok = (cfg_len != 5'd0) && (cfg_len <= PAT_MAX_L);

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    match_d = 1'b0;
    err_d   = 1'b0;

    // A config strobe always wins over din in the same cycle; that bit is dropped.
    if (cfg_load) begin
      if (cfg_ok) begin
        state_d = ARMED;
        pat_d   = cfg_pattern;
        len_d   = cfg_len;
        ovl_d   = cfg_overlap;
        hist_d  = '0;
        fill_d  = '0;
        cnt_d   = '0;
      end else begin
        err_d = 1'b1;
      end
    end else if (state_q == ARMED && din_valid) begin
      hist_d = {hist_q[PAT_MAX-2:0], din};
      fill_d = (fill_q < PAT_MAX_L) ? fill_q + 5'd1 : fill_q;
      if (fill_d >= len_q && ((hist_d ^ pat_q) & len_mask) == '0) begin
        match_d = 1'b1;
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
        if (!ovl_q) fill_d = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
      hist_q  <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      match_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      match_q <= match_d;
      err_q   <= err_d;
    end
  end

  assign match       = match_q;
  assign match_count = cnt_q;
  assign armed       = (state_q == ARMED);
  assign cfg_err     = err_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: one default instance and one with a
// 2-bit counter sharing the same stimulus to exercise counter saturation.
module tb_seq_detect_param;

  localparam int PAT_MAX = 8;

  logic               clock = 1'b0;
  logic               reset;
  logic               cfg_load;
  logic [PAT_MAX-1:0] cfg_pattern;
  logic [4:0]         cfg_len;
  logic               cfg_overlap;
  logic               din_valid;
  logic               din;

  logic               match, armed, cfg_err;
  logic [7:0]         match_count;
  logic               match2, armed2, cfg_err2;
  logic [1:0]         match_count2;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  seq_detect_param #(.PAT_MAX(PAT_MAX), .CNT_W(8)) u_dut (
    .clock(clock), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .din_valid(din_valid), .din(din),
    .match(match), .match_count(match_count), .armed(armed), .cfg_err(cfg_err)
  );

  seq_detect_param #(.PAT_MAX(PAT_MAX), .CNT_W(2)) u_dut2 (
    .clock(clock), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .din_valid(din_valid), .din(din),
    .match(match2), .match_count(match_count2), .armed(armed2), .cfg_err(cfg_err2)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [7:0] pat, input logic [4:0] len, input logic ovl);
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
    cfg_load    = 1'b1;
    tick();
    cfg_load    = 1'b0;
    $display("load pat=%h len=%0d ovl=%0d -> armed=%0d err=%0d", pat, len, ovl, armed, cfg_err);
  endtask

  // Sends n bits MSB-first from bits; exp holds the expected match after each bit.
  task automatic stream(input string tag, input logic [15:0] bits,
                        input logic [15:0] exp, input int n);
    logic b, e;
    for (int i = n - 1; i >= 0; i--) begin
      b = bits[i];
      e = exp[i];
      din_valid = 1'b1;
      din       = b;
      tick();
      din_valid = 1'b0;
      $display("%s bit%0d din=%0d match=%0d count=%0d", tag, n - 1 - i, b, match, match_count);
      chk($sformatf("%s_match_bit%0d", tag, n - 1 - i), 32'(match), 32'(e));
    end
  endtask

  initial begin
    reset = 1'b1; cfg_load = 1'b1; cfg_pattern = 8'h09; cfg_len = 5'd4;
    cfg_overlap = 1'b1; din_valid = 1'b1; din = 1'b1;
    // Reset has priority over a simultaneous load and valid bit.
    tick(); tick();
    cfg_load = 1'b0; din_valid = 1'b0; reset = 1'b0;
    chk("rst_armed", 32'(armed), 32'd0);
    chk("rst_match", 32'(match), 32'd0);
    chk("rst_count", 32'(match_count), 32'd0);
    chk("rst_err",   32'(cfg_err), 32'd0);

    // Idle ignores din.
    stream("idle", 16'b1, 16'b0, 1);
    chk("idle_armed", 32'(armed), 32'd0);

    // Overlapping 1001 over 1001001: matches at bits 4 and 7.
    load(8'h09, 5'd4, 1'b1);
    chk("load_armed", 32'(armed), 32'd1);
    stream("ovl", 16'b1001001, 16'b0001001, 7);
    chk("ovl_count", 32'(match_count), 32'd2);

    // Non-overlapping: single match.
    load(8'h09, 5'd4, 1'b0);
    chk("load_clears_count", 32'(match_count), 32'd0);
    stream("novl", 16'b1001001, 16'b0001000, 7);
    chk("novl_count", 32'(match_count), 32'd1);

    // Rejected loads: cfg_err pulses, state/config/count untouched.
    load(8'hFF, 5'd0, 1'b1);
    chk("err0_pulse", 32'(cfg_err), 32'd1);
    chk("err0_armed", 32'(armed), 32'd1);
    chk("err0_match", 32'(match), 32'd0);
    tick();
    chk("err0_single", 32'(cfg_err), 32'd0);
    load(8'hFF, 5'(PAT_MAX + 1), 1'b1);
    chk("err9_pulse", 32'(cfg_err), 32'd1);
    chk("err9_count", 32'(match_count), 32'd1);
    // History still holds ..001 with fill 3 in non-overlap mode.
    stream("after_err", 16'b1001, 16'b0001, 4);
    chk("after_err_count", 32'(match_count), 32'd2);
    chk("after_err_noerr", 32'(cfg_err), 32'd0);

    // Invalid gap cycles with din=1 are ignored.
    load(8'h09, 5'd4, 1'b1);
    stream("gap_a", 16'b10, 16'b00, 2);
    din = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("gap_idle%0d", i), 32'(match), 32'd0);
    end
    stream("gap_b", 16'b01, 16'b01, 2);

    // Mid-stream reset discards the partial match.
    load(8'h09, 5'd4, 1'b1);
    stream("pre_rst", 16'b100, 16'b000, 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_armed", 32'(armed), 32'd0);
    load(8'h09, 5'd4, 1'b1);
    stream("post_rst", 16'b1, 16'b0, 1);
    chk("post_rst_count", 32'(match_count), 32'd0);

    // Bit that arrives with cfg_load is discarded.
    cfg_pattern = 8'h03; cfg_len = 5'd2; cfg_overlap = 1'b1;
    cfg_load = 1'b1; din_valid = 1'b1; din = 1'b1;
    tick();
    cfg_load = 1'b0; din_valid = 1'b0;
    stream("discard", 16'b11, 16'b01, 2);

    // Full-length pattern.
    load(8'hA5, 5'd8, 1'b0);
    stream("len8", 16'b10100101, 16'b00000001, 8);

    // len=1 pattern=1: every 1 matches; 2-bit counter saturates at 3.
    load(8'h01, 5'd1, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      din_valid = 1'b1; din = 1'b1;
      tick();
      din_valid = 1'b0;
      $display("sat bit%0d match2=%0d count2=%0d", i, match2, match_count2);
      chk($sformatf("sat_match%0d", i), 32'(match2), 32'd1);
      chk($sformatf("sat_count%0d", i), 32'(match_count2), (i < 3) ? 32'(i) : 32'd3);
    end
    chk("len1_count8", 32'(match_count), 32'd5);
    stream("len1_zero", 16'b0, 16'b0, 1);
    tick();
    chk("len1_pulse_end", 32'(match2), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 Parameter PAT_MAX, default 8, maximum pattern length in bits; legal range 2..16.
REQ-002 Parameter CNT_W, default 8, width of the match counter.
REQ-003 clock  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cfg_load  input  1  one-cycle strobe that captures cfg_pattern, cfg_len and cfg_overlap.
REQ-006 cfg_pattern  input  PAT_MAX  target pattern; bit [cfg_len-1] is the first serial bit and bit [0] is the last.
REQ-007 cfg_len  input  5  pattern length; legal values are 1..PAT_MAX.
REQ-008 cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping detection.
REQ-009 din_valid  input  1  qualifies din; bits with din_valid=0 are ignored.
REQ-010 din  input  1  serial data bit.
REQ-011 match  output  1  registered one-cycle pulse per detected pattern.
REQ-012 match_count  output  CNT_W  saturating count of matches since the last reset or accepted cfg_load.
REQ-013 armed  output  1  high while in state ARMED.
REQ-014 cfg_err  output  1  registered one-cycle pulse on rejected cfg_load.

Function
REQ-015 The block SHALL have two states: IDLE and ARMED.
- IDLE: din is ignored.
- ARMED: din is processed.
REQ-016 An accepted cfg_load (cfg_len in 1..PAT_MAX) SHALL, in any state, have the following effects at the next edge:
- latch the configuration;
- clear history, fill count and match_count;
- force match=0;
- enter ARMED.
REQ-017 A cfg_load with cfg_len=0 or cfg_len>PAT_MAX SHALL:
- pulse cfg_err for one cycle;
- leave the state, the stored configuration, the history and match_count unchanged.
REQ-018 When din_valid=1 in the same cycle as cfg_load (accepted or rejected), that din SHALL be discarded.
REQ-019 In ARMED, each din_valid=1 edge SHALL:
- shift din into bit 0 of a PAT_MAX-bit history register (hist <= {hist[PAT_MAX-2:0], din});
- increment the fill count, saturating at PAT_MAX.
REQ-020 A match SHALL occur on an accepting edge when both hold:
- the post-shift fill count is >= cfg_len;
- the post-shift hist[cfg_len-1:0] equals the stored pattern[cfg_len-1:0].
REQ-021 match SHALL be high for exactly the one cycle following the edge that sampled the completing bit (latency 1 clock from sampling), and low otherwise.
REQ-022 With cfg_overlap=1, the fill count SHALL NOT be cleared on a match, so a suffix of one match can begin the next.
REQ-023 With cfg_overlap=0, the fill count SHALL be cleared to 0 on the matching edge, so the next match needs cfg_len fresh bits.
REQ-024 On each match, match_count SHALL increment by 1; at all-ones it SHALL hold, and match SHALL still pulse.
REQ-025 Gaps with din_valid=0 SHALL NOT disturb the history, the fill count or any pending partial match.
REQ-026 match and cfg_err SHALL NOT both be asserted in the same cycle.
REQ-027 With cfg_len=1, every accepted bit equal to pattern[0] SHALL produce a match.

Reset
REQ-028 reset=1 at an edge SHALL:
- force IDLE;
- clear the history, the fill count and the stored configuration (pattern=0, len=0, overlap=0);
- clear match, match_count, armed and cfg_err to 0.
REQ-029 reset SHALL take priority over a simultaneous cfg_load and din_valid.
REQ-030 Reset asserted mid-stream SHALL discard any partial match; no match SHALL be reported for bits sampled before reset deassertion.
REQ-031 After reset, the block SHALL remain in IDLE, ignoring din, until an accepted cfg_load.

Verification
REQ-032 Load pattern=4'b1001, len=4, overlap=1; stream 1,0,0,1,0,0,1 -> match pulses the cycle after bits 4 and 7; match_count=2.
REQ-033 Same pattern and stream with overlap=0 -> single match after bit 4; match_count=1.
REQ-034 cfg_load with cfg_len=0, then cfg_len=PAT_MAX+1 -> cfg_err pulses each time; armed and the prior pattern are unchanged, and detection continues.
REQ-035 Stream 1,0,0 then reset, then cfg_load 1001 again, then stream 1 -> no match; match_count=0.
REQ-036 CNT_W=2, len=1, pattern=1, five valid 1s -> five match pulses; match_count saturates at 3.
REQ-037 Stream 1,0,(din_valid=0 for 3 cycles with din=1),0,1 -> match after the final 1; the invalid cycles are ignored.
